// File: rtl/kbest_layer_sched_if.sv
// Bundle of scheduler handshake signals: vector intake, engine control,
// shared sorter control, result output and status.
//
// Handshake rule (both in_* and out_*): a transfer happens on a rising clk
// edge where valid and ready are both 1; the source holds valid and its
// payload stable until that edge, and ready may not depend on valid.
interface kbest_layer_sched_if #(
    parameter int TAGW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [TAGW-1:0] in_tag;
    logic            eng_start;
    logic [1:0]      eng_pair;
    logic            eng_first;
    logic            eng_done;
    logic            sort_en;
    logic [3:0]      sort_step;
    logic            out_valid;
    logic            out_ready;
    logic [TAGW-1:0] out_tag;
    logic            err;
    logic [15:0]     vec_cnt;
    logic [2:0]      state;      // debug view of the FSM state

    // Scheduler side.
    modport master (
        input  in_valid, in_tag, eng_done, out_ready,
        output in_ready, eng_start, eng_pair, eng_first, sort_en, sort_step,
               out_valid, out_tag, err, vec_cnt, state
    );

    // Environment side: vector source, engine, sorter and result sink.
    modport slave (
        output in_valid, in_tag, eng_done, out_ready,
        input  in_ready, eng_start, eng_pair, eng_first, sort_en, sort_step,
               out_valid, out_tag, err, vec_cnt, state
    );
endinterface

// File: rtl/kbest_layer_sched.sv
// K-best layer-pair scheduler: accepts one received vector, walks the layer
// pairs from the top pair down to pair 0, launching the expansion engine and
// then the shared PED sorter for each pair, and finally presents the vector
// tag as a completed result. A missing eng_done aborts the vector with err.
module kbest_layer_sched #(
    parameter int NPAIR    = 4,
    parameter int SORT_CYC = 16,
    parameter int TIMEOUT  = 255,
    parameter int TAGW     = 8
) (
    input logic               clk,
    input logic               rstn,
    kbest_layer_sched_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        SORT  = 3'd3,
        OUT   = 3'd4
    } state_e;

    localparam int         WCW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [1:0] PAIR_TOP  = 2'(NPAIR - 1);
    localparam logic [3:0] SORT_LAST = 4'(SORT_CYC - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [1:0]      pair_q, pair_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]      sort_step_q, sort_step_d;
    logic [TAGW-1:0] out_tag_q, out_tag_d;
    logic [15:0]     vec_cnt_q, vec_cnt_d;
    logic            eng_start_q, eng_start_d;
    logic            sort_en_q, sort_en_d;
    logic            out_valid_q, out_valid_d;
    logic            err_q, err_d;

    // State, counters and registered outputs; async active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pair_q      <= PAIR_TOP;
            wait_cnt_q  <= '0;
            sort_step_q <= '0;
            out_tag_q   <= '0;
            vec_cnt_q   <= '0;
            eng_start_q <= 1'b0;
            sort_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pair_q      <= pair_d;
            wait_cnt_q  <= wait_cnt_d;
            sort_step_q <= sort_step_d;
            out_tag_q   <= out_tag_d;
            vec_cnt_q   <= vec_cnt_d;
            eng_start_q <= eng_start_d;
            sort_en_q   <= sort_en_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    // Next-state and next-output decode; pulse outputs are derived from the
    // upcoming state so they line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        pair_d      = pair_q;
        wait_cnt_d  = wait_cnt_q;
        sort_step_d = '0;
        out_tag_d   = out_tag_q;
        vec_cnt_d   = vec_cnt_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    out_tag_d = bus.in_tag;
                    pair_d    = PAIR_TOP;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // eng_done is checked first so it wins over the expiry.
                if (bus.eng_done) begin
                    state_d = SORT;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_d      = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            SORT: begin
                if (sort_step_q == SORT_LAST) begin
                    if (pair_q == 2'd0) begin
                        state_d = OUT;
                    end else begin
                        pair_d  = pair_q - 2'd1;
                        state_d = ISSUE;
                    end
                end else begin
                    sort_step_d = sort_step_q + 4'd1;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    vec_cnt_d = vec_cnt_q + 16'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        eng_start_d = (state_d == ISSUE);
        sort_en_d   = (state_d == SORT);
        out_valid_d = (state_d == OUT);
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.eng_first = (pair_q == PAIR_TOP);
    assign bus.eng_start = eng_start_q;
    assign bus.eng_pair  = pair_q;
    assign bus.sort_en   = sort_en_q;
    assign bus.sort_step = sort_step_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.err       = err_q;
    assign bus.vec_cnt   = vec_cnt_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_kbest_layer_sched.sv
// Testbench for kbest_layer_sched: lockstep stimulus with a tag scoreboard.
module tb_kbest_layer_sched;

    localparam int NPAIR    = 4;
    localparam int SORT_CYC = 16;
    localparam int TIMEOUT  = 8;
    localparam int TAGW     = 8;

    logic clk;
    logic rstn;

    kbest_layer_sched_if #(.TAGW(TAGW)) bif ();

    kbest_layer_sched #(
        .NPAIR(NPAIR), .SORT_CYC(SORT_CYC), .TIMEOUT(TIMEOUT), .TAGW(TAGW)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bif)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int starts_seen = 0;
    int err_seen = 0;
    logic [15:0] exp_cnt = '0;
    logic [TAGW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle, sample #1 after the edge, tally pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        starts_seen += int'(bif.eng_start);
        err_seen    += int'(bif.err);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(bif.in_ready), 1);
        check({tag, "_eng_start"}, 32'(bif.eng_start), 0);
        check({tag, "_sort_en"},   32'(bif.sort_en), 0);
        check({tag, "_sort_step"}, 32'(bif.sort_step), 0);
        check({tag, "_out_valid"}, 32'(bif.out_valid), 0);
        check({tag, "_err"},       32'(bif.err), 0);
        check({tag, "_out_tag"},   32'(bif.out_tag), 0);
        check({tag, "_vec_cnt"},   32'(bif.vec_cnt), 0);
        check({tag, "_eng_pair"},  32'(bif.eng_pair), NPAIR - 1);
        check({tag, "_eng_first"}, 32'(bif.eng_first), 1);
        check({tag, "_state"},     32'(bif.state), 0);
    endtask

    // Drive one vector through all pairs. dw = WAIT cycle carrying eng_done,
    // stall = cycles of out_ready low in OUT, spur = eng_done pulse mid-SORT,
    // ab_pair/ab_step = where to assert reset (-1: never).
    task automatic run_vector(input logic [TAGW-1:0] tag, input int dw, input int stall,
                              input bit spur, input int ab_pair, input int ab_step);
        int s0;
        int e0;
        logic [TAGW-1:0] got_tag;
        check("idle_in_ready", 32'(bif.in_ready), 1);
        bif.out_ready = (stall == 0);
        bif.in_valid  = 1'b1;
        bif.in_tag    = tag;
        s0 = starts_seen;
        e0 = err_seen;
        tick();
        bif.in_valid = 1'b0;
        bif.in_tag   = '0;
        exp_q.push_back(tag);
        for (int p = NPAIR - 1; p >= 0; p--) begin
            check("issue_start",    32'(bif.eng_start), 1);
            check("issue_pair",     32'(bif.eng_pair), 32'(p));
            check("issue_first",    32'(bif.eng_first), 32'(p == NPAIR - 1));
            check("issue_in_ready", 32'(bif.in_ready), 0);
            for (int w = 1; w <= dw; w++) begin
                tick();
                if (w == 1) check("wait_start_low", 32'(bif.eng_start), 0);
                bif.eng_done = (w == dw);
            end
            tick();
            bif.eng_done = 1'b0;
            for (int s = 0; s < SORT_CYC; s++) begin
                check("sort_en",   32'(bif.sort_en), 1);
                check("sort_step", 32'(bif.sort_step), 32'(s));
                check("sort_pair", 32'(bif.eng_pair), 32'(p));
                if (s == 0) check("sort_no_err", 32'(bif.err), 0);
                if (p == ab_pair && s == ab_step) begin
                    rstn = 1'b0;
                    #1;
                    exp_q.delete();
                    exp_cnt = '0;
                    check_reset_values("midsort_rst");
                    tick();
                    rstn = 1'b1;
                    tick();
                    check("post_rst_in_ready", 32'(bif.in_ready), 1);
                    check("post_rst_err_none", 32'(err_seen - e0), 0);
                    return;
                end
                bif.eng_done = spur && (s == 5);
                tick();
                bif.eng_done = 1'b0;
            end
        end
        check("out_valid_arrive", 32'(bif.out_valid), 1);
        check("eng_start_count",  32'(starts_seen - s0), NPAIR);
        for (int k = 0; k < stall; k++) begin
            check("stall_out_valid", 32'(bif.out_valid), 1);
            check("stall_out_tag",   32'(bif.out_tag), 32'(exp_q[0]));
            check("stall_in_ready",  32'(bif.in_ready), 0);
            check("stall_vec_cnt",   32'(bif.vec_cnt), 32'(exp_cnt));
            tick();
        end
        check("hs_out_valid", 32'(bif.out_valid), 1);
        got_tag = bif.out_tag;
        bif.out_ready = 1'b1;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        check("out_tag",        32'(got_tag), 32'(exp_q.pop_front()));
        check("vec_cnt",        32'(bif.vec_cnt), 32'(exp_cnt));
        check("post_out_valid", 32'(bif.out_valid), 0);
        check("post_in_ready",  32'(bif.in_ready), 1);
        check("vector_no_err",  32'(err_seen - e0), 0);
    endtask

    // Vector whose engine never answers: expect one err pulse and a return to IDLE.
    task automatic run_timeout(input logic [TAGW-1:0] tag);
        int e0;
        check("to_in_ready", 32'(bif.in_ready), 1);
        bif.in_valid = 1'b1;
        bif.in_tag   = tag;
        tick();
        bif.in_valid = 1'b0;
        e0 = err_seen;
        check("to_issue_start", 32'(bif.eng_start), 1);
        for (int w = 1; w <= TIMEOUT; w++) begin
            tick();
            check("to_wait_err_low", 32'(bif.err), 0);
            check("to_wait_busy",    32'(bif.in_ready), 0);
        end
        tick();
        check("to_err_pulse", 32'(bif.err), 1);
        check("to_idle",      32'(bif.in_ready), 1);
        check("to_no_sort",   32'(bif.sort_en), 0);
        check("to_vec_cnt",   32'(bif.vec_cnt), 32'(exp_cnt));
        tick();
        check("to_err_once",  32'(err_seen - e0), 1);
        check("to_err_low",   32'(bif.err), 0);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TAGW-1:0] tg;
        rstn          = 1'b0;
        bif.in_valid  = 1'b0;
        bif.in_tag    = '0;
        bif.eng_done  = 1'b0;
        bif.out_ready = 1'b1;
        tick();
        tick();
        check_reset_values("reset");
        rstn = 1'b1;
        tick();
        check("release_in_ready", 32'(bif.in_ready), 1);

        // eng_done while idle must be ignored
        bif.eng_done = 1'b1;
        tick();
        bif.eng_done = 1'b0;
        check("idle_done_state",  32'(bif.state), 0);
        check("idle_done_nostart", 32'(bif.eng_start), 0);
        tick();
        check("idle_done_ready",  32'(bif.in_ready), 1);

        run_vector(8'h5A, 3, 0, 1'b0, -1, -1);   // nominal
        run_vector(8'hC3, 2, 10, 1'b0, -1, -1);  // backpressure
        run_timeout(8'h77);                      // timeout
        run_vector(8'h11, TIMEOUT, 0, 1'b0, -1, -1); // done on the expiry cycle
        run_vector(8'h22, 4, 0, 1'b1, -1, -1);   // spurious done in SORT
        run_vector(8'h33, 3, 0, 1'b0, 2, 7);     // reset mid-SORT
        run_vector(8'h44, 1, 0, 1'b0, -1, -1);   // restarts at the top pair
        for (int i = 0; i < 3; i++) begin
            tg = TAGW'($urandom_range(0, 255));
            run_vector(tg, $urandom_range(1, TIMEOUT), $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1, -1);
        end

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
